serial_comparator: RTL and testbench
====================================

// Module: serial_comparator
//
// PURPOSE
//   Multi-cycle magnitude comparator for wide unsigned operands.
//   Captures A and B on a start request, then walks the operands MSB-first,
//   one 2-bit slice per clock, and stops at the first slice that differs.
//   Reports Lesser/Greater/Equal with a one-cycle done pulse.
//   Sits between operand producers and control logic where a full-width
//   combinational compare is too slow or too large.
//
// PARAMETERS
//   WIDTH   8   Operand width in bits. Must be even and >= 2.
//               SLICES = WIDTH/2 (number of 2-bit slices).
//
// PORTS
//   clk      in   1      Single clock; all state updates on the rising edge.
//   rst_n    in   1      Reset, asynchronous, active-low.
//   start    in   1      Compare request; sampled only in IDLE.
//   A        in   WIDTH  Operand A, unsigned; sampled with start.
//   B        in   WIDTH  Operand B, unsigned; sampled with start.
//   busy     out  1      High while in RUN.
//   done     out  1      One-cycle pulse; results valid from this cycle.
//   Lesser   out  1      A < B.
//   Greater  out  1      A > B.
//   Equal    out  1      A == B.
//
// BEHAVIOUR
//   Reset (rst_n=0, asynchronous):
//     - state=IDLE; busy=0, done=0, Lesser=0, Greater=0, Equal=0.
//     - Internal operand registers and slice index cleared.
//     - Reset during RUN aborts the operation: no done pulse and no result.
//   FSM, two states:
//     - IDLE:
//       - start=1 at edge E0: register A/B, set idx=SLICES-1, clear all three
//         results to 0, done=0, go to RUN.
//       - start=0: hold results, done=0.
//     - RUN (busy=1): each edge compares A_r[2*idx+1:2*idx] against the
//       matching B_r slice.
//       - Slices differ: set Lesser or Greater from the slice relation,
//         done=1, go to IDLE.
//       - Slices equal and idx==0: Equal=1, done=1, go to IDLE.
//       - Slices equal and idx>0: idx decrements, stay in RUN.
//   Latency:
//     - If the first differing slice is the m-th slice examined (m=1..SLICES),
//       done and results appear after edge E0+m.
//     - An equal result always takes SLICES cycles.
//   Outputs:
//     - All outputs are registered.
//     - At most one of Lesser/Greater/Equal is 1. Exactly one is 1 from done
//       until the next accepted start; all are 0 while busy.
//   start handling:
//     - start while busy is ignored. Operands are not resampled and the
//       in-flight result is unaffected.
//     - start in the cycle done=1 (state is IDLE) is accepted: that edge clears
//       the results and done, and RUN begins again.
//   Width rules:
//     - The compare is unsigned and needs no arithmetic carry.
//     - idx width is clog2(SLICES), minimum 1 bit.
//
// TESTING
//   T1 WIDTH=8, A=8'hC3, B=8'h43, pulse start -> done after E0+1, Greater=1,
//      others 0.
//   T2 A=B=8'h5A -> busy for 4 cycles, done after E0+4, Equal=1.
//   T3 A=8'h12, B=8'h13 (only LSB slice differs) -> done after E0+4, Lesser=1.
//   T4 Start A=8'h00, B=8'h00, then start with A=8'hFF after E0+1 while busy
//      -> ignored, Equal=1 after E0+4. Next, assert start with A=8'h80, B=8'h00
//      in the done cycle -> accepted, results read 0 after that edge, then
//      Greater=1 one cycle later.
//   T5 A=B=8'hA5, drive rst_n=0 after E0+2 -> all outputs 0 immediately, no
//      done. Release reset, then run A=8'h01, B=8'h02 -> Lesser=1 after E0+4.
//   T6 WIDTH=2, exhaustive 16 A/B pairs, plus 10k random WIDTH=8 pairs against
//      a behavioural model -> every result matches, done after E0+m, and the
//      result flags stay one-hot from done onward.

Source files
------------

// File: rtl/serial_comparator.sv
// serial_comparator: multi-cycle unsigned magnitude comparator.
// Operands are captured on an accepted start and walked MSB-first, one
// 2-bit slice per clock. The walk stops at the first differing slice, so a
// mismatch in the upper bits resolves quickly and only equal operands pay
// the full SLICES-cycle latency. Every output comes straight from a flop.

module serial_comparator #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             Lesser,
  output logic             Greater,
  output logic             Equal
);

  localparam int SLICES = WIDTH / 2;
  localparam int IDXW   = (SLICES > 1) ? $clog2(SLICES) : 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] a_s;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] b_s;
  logic [IDXW-1:0]  idx_r;
  logic [IDXW-1:0]  idx_s;
  logic             busy_r;
  logic             busy_s;
  logic             done_r;
  logic             done_s;
  logic             lesser_r;
  logic             lesser_s;
  logic             greater_r;
  logic             greater_s;
  logic             equal_r;
  logic             equal_s;

  logic [WIDTH-1:0] a_shift_s;
  logic [WIDTH-1:0] b_shift_s;
  logic [1:0]       a_slice_s;
  logic [1:0]       b_slice_s;
  logic [1:0]       order_s;

  // Relation of two 2-bit slices as {a<b, a>b}; decided bit by bit from the
  // top, so no subtractor or carry chain is needed. 2'b00 means equal.
  function automatic logic [1:0] slice_order(input logic [1:0] sa,
                                             input logic [1:0] sb);
    logic [1:0] rel;
    rel = 2'b00;
    if (sa[1] != sb[1]) begin
      rel = sb[1] ? 2'b10 : 2'b01;
    end else if (sa[0] != sb[0]) begin
      rel = sb[0] ? 2'b10 : 2'b01;
    end else begin
      rel = 2'b00;
    end
    return rel;
  endfunction

  // Select the slice under examination and classify it.
  always_comb begin
    a_shift_s = a_r >> {idx_r, 1'b0};
    b_shift_s = b_r >> {idx_r, 1'b0};
    a_slice_s = a_shift_s[1:0];
    b_slice_s = b_shift_s[1:0];
    order_s   = slice_order(a_slice_s, b_slice_s);
  end

  // Next-state and next-output logic; everything holds unless a branch says otherwise.
  always_comb begin
    state_s   = state_r;
    a_s       = a_r;
    b_s       = b_r;
    idx_s     = idx_r;
    busy_s    = busy_r;
    done_s    = 1'b0;
    lesser_s  = lesser_r;
    greater_s = greater_r;
    equal_s   = equal_r;

    case (state_r)
      ST_IDLE: begin
        if (start) begin
          // Accept: latch operands, begin at the most significant slice and
          // clear the previous verdict so nothing stale shows while busy.
          a_s       = A;
          b_s       = B;
          idx_s     = IDXW'(SLICES - 1);
          lesser_s  = 1'b0;
          greater_s = 1'b0;
          equal_s   = 1'b0;
          busy_s    = 1'b1;
          state_s   = ST_RUN;
        end else begin
          busy_s    = 1'b0;
        end
      end

      ST_RUN: begin
        if (order_s != 2'b00) begin
          // First differing slice decides the whole comparison.
          lesser_s  = order_s[1];
          greater_s = order_s[0];
          equal_s   = 1'b0;
          done_s    = 1'b1;
          busy_s    = 1'b0;
          state_s   = ST_IDLE;
        end else if (idx_r == {IDXW{1'b0}}) begin
          // Every slice matched.
          lesser_s  = 1'b0;
          greater_s = 1'b0;
          equal_s   = 1'b1;
          done_s    = 1'b1;
          busy_s    = 1'b0;
          state_s   = ST_IDLE;
        end else begin
          idx_s     = idx_r - IDXW'(1);
          busy_s    = 1'b1;
        end
      end

      default: begin
        // Unreachable encoding: fall back to a clean idle with no verdict.
        state_s   = ST_IDLE;
        busy_s    = 1'b0;
        lesser_s  = 1'b0;
        greater_s = 1'b0;
        equal_s   = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any compare in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      a_r       <= {WIDTH{1'b0}};
      b_r       <= {WIDTH{1'b0}};
      idx_r     <= {IDXW{1'b0}};
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      lesser_r  <= 1'b0;
      greater_r <= 1'b0;
      equal_r   <= 1'b0;
    end else begin
      state_r   <= state_s;
      a_r       <= a_s;
      b_r       <= b_s;
      idx_r     <= idx_s;
      busy_r    <= busy_s;
      done_r    <= done_s;
      lesser_r  <= lesser_s;
      greater_r <= greater_s;
      equal_r   <= equal_s;
    end
  end

  assign busy    = busy_r;
  assign done    = done_r;
  assign Lesser  = lesser_r;
  assign Greater = greater_r;
  assign Equal   = equal_r;

endmodule

// File: tb/tb_serial_comparator.sv
// Bench for serial_comparator: a WIDTH=8 and a WIDTH=2 instance, each
// shadowed by an arithmetic model (verdict from plain < / >, latency from
// the position of the highest differing bit), checked every cycle, plus
// hand-computed literal checks for the directed scenarios.

module tb_serial_comparator;

  logic            clk;
  logic            rst_n;
  logic [1:0]      start_v;
  logic [1:0][7:0] a_v;
  logic [1:0][7:0] b_v;
  logic [1:0]      busy_v;
  logic [1:0]      done_v;
  logic [1:0]      lt_v;
  logic [1:0]      gt_v;
  logic [1:0]      eq_v;

  int n_vec;
  int n_err;
  int cyc;
  int e0 [2];
  bit chk_en;

  serial_comparator #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]),
    .A(a_v[0]), .B(b_v[0]),
    .busy(busy_v[0]), .done(done_v[0]),
    .Lesser(lt_v[0]), .Greater(gt_v[0]), .Equal(eq_v[0])
  );

  serial_comparator #(.WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]),
    .A(a_v[1][1:0]), .B(b_v[1][1:0]),
    .busy(busy_v[1]), .done(done_v[1]),
    .Lesser(lt_v[1]), .Greater(gt_v[1]), .Equal(eq_v[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int wid(input int i);
    return (i == 0) ? 8 : 2;
  endfunction

  // Expected verdict {Lesser, Greater, Equal} from ordinary integer compare.
  function automatic logic [2:0] exp_res(input logic [7:0] a, input logic [7:0] b, input int w);
    int ai;
    int bi;
    ai = int'(a) & ((1 << w) - 1);
    bi = int'(b) & ((1 << w) - 1);
    if (ai < bi) return 3'b100;
    if (ai > bi) return 3'b010;
    return 3'b001;
  endfunction

  // Expected latency: the slice holding the highest differing bit decides.
  function automatic int exp_lat(input logic [7:0] a, input logic [7:0] b, input int w);
    int x;
    int p;
    x = (int'(a) ^ int'(b)) & ((1 << w) - 1);
    if (x == 0) return w / 2;
    p = 0;
    for (int k = 0; k < w; k++) if (x[k]) p = k;
    return w / 2 - p / 2;
  endfunction

  // Behavioural model state per instance.
  logic [1:0]      m_busy;
  logic [1:0]      m_done;
  logic [1:0][2:0] m_res;
  logic [1:0][2:0] m_pend;
  int              m_cnt [2];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_busy[i] <= 1'b0;
        m_done[i] <= 1'b0;
        m_res[i]  <= 3'b000;
        m_pend[i] <= 3'b000;
        m_cnt[i]  <= 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (!m_busy[i]) begin
          m_done[i] <= 1'b0;
          if (start_v[i]) begin
            m_busy[i] <= 1'b1;
            m_res[i]  <= 3'b000;
            m_cnt[i]  <= exp_lat(a_v[i], b_v[i], wid(i));
            m_pend[i] <= exp_res(a_v[i], b_v[i], wid(i));
          end
        end else if (m_cnt[i] <= 1) begin
          m_busy[i] <= 1'b0;
          m_done[i] <= 1'b1;
          m_res[i]  <= m_pend[i];
        end else begin
          m_cnt[i]  <= m_cnt[i] - 1;
        end
      end
    end
  end

  function automatic logic [4:0] outs(input int i);
    return {busy_v[i], done_v[i], lt_v[i], gt_v[i], eq_v[i]};
  endfunction

  // Every-cycle compare of both instances against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        n_vec = n_vec + 1;
        if (outs(i) !== {m_busy[i], m_done[i], m_res[i]}) begin
          n_err = n_err + 1;
          $display("FAIL model_w%0d cyc=%0d got busy,done,L,G,E=%b want %b",
                   wid(i), cyc, outs(i), {m_busy[i], m_done[i], m_res[i]});
        end
      end
    end
  end

  task automatic lit(input string name, input logic [4:0] got, input logic [4:0] want);
    n_vec = n_vec + 1;
    if (got !== want) begin
      n_err = n_err + 1;
      $display("FAIL %s got %b want %b", name, got, want);
    end
  endtask

  task automatic lat_chk(input string name, input int got, input int want);
    n_vec = n_vec + 1;
    if (got != want) begin
      n_err = n_err + 1;
      $display("FAIL %s latency got %0d want %0d", name, got, want);
    end
  endtask

  // Pulse start for one edge (E0); returns outputs just after E0.
  task automatic launch(input int i, input logic [7:0] a, input logic [7:0] b,
                        output logic [4:0] snap);
    a_v[i]     = a;
    b_v[i]     = b;
    start_v[i] = 1'b1;
    @(posedge clk);
    #1;
    e0[i]      = cyc;
    start_v[i] = 1'b0;
    snap       = outs(i);
  endtask

  // Wait (bounded) for done; optional junk start/operands while busy.
  task automatic wait_done(input int i, input bit noise, output int lat);
    bit got;
    got = 1'b0;
    lat = -1;
    for (int k = 0; k < 12 && !got; k++) begin
      if (noise) begin
        start_v[i] = 1'($urandom_range(0, 1));
        a_v[i]     = 8'($urandom);
        b_v[i]     = 8'($urandom);
      end
      @(posedge clk);
      #1;
      if (done_v[i]) begin
        got = 1'b1;
        lat = cyc - e0[i];
      end
    end
    start_v[i] = 1'b0;
    if (!got) begin
      n_vec = n_vec + 1;
      n_err = n_err + 1;
      $display("FAIL timeout_w%0d no done within 12 cycles", wid(i));
    end
  endtask

  initial begin
    logic [4:0] snap;
    logic [7:0] ra;
    logic [7:0] rb;
    int         lat;

    n_vec   = 0;
    n_err   = 0;
    cyc     = 0;
    chk_en  = 1'b0;
    rst_n   = 1'b0;
    start_v = 2'b00;
    a_v     = '0;
    b_v     = '0;

    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    lit("reset_w8", outs(0), 5'b00000);
    lit("reset_w2", outs(1), 5'b00000);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // T1: top slice differs -> Greater after one cycle.
    launch(0, 8'hC3, 8'h43, snap);
    lit("t1_busy", snap, 5'b10000);
    wait_done(0, 1'b0, lat);
    lat_chk("t1", lat, 1);
    lit("t1_res", outs(0), 5'b01010);
    @(posedge clk); #1;

    // T2: equal operands walk all four slices.
    launch(0, 8'h5A, 8'h5A, snap);
    wait_done(0, 1'b0, lat);
    lat_chk("t2", lat, 4);
    lit("t2_res", outs(0), 5'b01001);
    @(posedge clk); #1;
    lit("t2_hold", outs(0), 5'b00001);

    // T3: only the LSB slice differs.
    launch(0, 8'h12, 8'h13, snap);
    wait_done(0, 1'b0, lat);
    lat_chk("t3", lat, 4);
    lit("t3_res", outs(0), 5'b01100);
    @(posedge clk); #1;

    // T4: start while busy is ignored; start in the done cycle is accepted.
    launch(0, 8'h00, 8'h00, snap);
    @(posedge clk); #1;
    a_v[0]     = 8'hFF;
    start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    wait_done(0, 1'b0, lat);
    lat_chk("t4a", lat, 4);
    lit("t4a_res", outs(0), 5'b01001);
    launch(0, 8'h80, 8'h00, snap);
    lit("t4b_clear", snap, 5'b10000);
    wait_done(0, 1'b0, lat);
    lat_chk("t4b", lat, 1);
    lit("t4b_res", outs(0), 5'b01010);
    @(posedge clk); #1;

    // T5: reset mid-run aborts; a fresh compare then works.
    launch(0, 8'hA5, 8'hA5, snap);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    lit("t5_rst", outs(0), 5'b00000);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    lit("t5_nodone", outs(0), 5'b00000);
    launch(0, 8'h01, 8'h02, snap);
    wait_done(0, 1'b0, lat);
    lat_chk("t5", lat, 4);
    lit("t5_res", outs(0), 5'b01100);
    @(posedge clk); #1;

    // T6a: WIDTH=2 exhaustive, junk start while busy.
    for (int a = 0; a < 4; a++) begin
      for (int b = 0; b < 4; b++) begin
        launch(1, 8'(a), 8'(b), snap);
        wait_done(1, 1'b1, lat);
        lat_chk("w2_exh", lat, exp_lat(8'(a), 8'(b), 2));
      end
    end
    @(posedge clk); #1;

    // T6b: random WIDTH=8 pairs, mostly back-to-back from the done cycle.
    for (int n = 0; n < 10000; n++) begin
      ra = 8'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? ra : 8'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
      launch(0, ra, rb, snap);
      wait_done(0, 1'b1, lat);
      lat_chk("w8_rand", lat, exp_lat(ra, rb, 8));
    end
    repeat (3) @(posedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
